// File: rtl/image_frame_tx.sv
// Image frame transmitter: streams one stored image from the pixel RAM into the
// UART TX FIFO as AA 55 W H <pixels> CHK, honouring tx_full backpressure.
module image_frame_tx #(
  parameter int unsigned IMG_W  = 64,
  parameter int unsigned IMG_H  = 48,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  input  logic              tx_full,
  output logic              wr_uart,
  output logic [7:0]        w_data,
  output logic              busy,
  output logic              done
);

  localparam int unsigned       NumPix   = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NumPix - 1);
  localparam logic [7:0]        WidByte  = 8'(IMG_W);
  localparam logic [7:0]        HgtByte  = 8'(IMG_H);

  typedef enum logic [3:0] {
    StIdle, StSync0, StSync1, StWid, StHgt, StRdReq, StRdWait, StPix, StChk, StFin
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        pix_q, pix_d;
  logic [7:0]        chk_q, chk_d;
  logic              send;
  logic              accept;

  // A byte leaves only from a send state while the FIFO has room.
  always_comb begin
    send = 1'b0;
    case (state_q)
      StSync0, StSync1, StWid, StHgt, StPix, StChk: send = 1'b1;
      default:                                      send = 1'b0;
    endcase
    accept = send & ~tx_full;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      pix_q   <= '0;
      chk_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pix_q   <= pix_d;
      chk_q   <= chk_d;
    end
  end

  // Next-state, address and checksum update.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pix_d   = pix_q;
    chk_d   = chk_q;
    if (abort && state_q != StIdle) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start && !abort) begin
            state_d = StSync0;
            addr_d  = '0;
            chk_d   = '0;
          end
        end
        StSync0: if (accept) state_d = StSync1;
        StSync1: if (accept) state_d = StWid;
        StWid: begin
          if (accept) begin
            state_d = StHgt;
            chk_d   = chk_q + WidByte;
          end
        end
        StHgt: begin
          if (accept) begin
            state_d = StRdReq;
            chk_d   = chk_q + HgtByte;
          end
        end
        StRdReq: state_d = StRdWait;
        StRdWait: begin
          state_d = StPix;
          pix_d   = mem_data;
          chk_d   = chk_q + mem_data;
        end
        StPix: begin
          if (accept) begin
            if (addr_q == LastAddr) begin
              state_d = StChk;
            end else begin
              state_d = StRdReq;
              addr_d  = addr_q + 1'b1;
            end
          end
        end
        StChk: if (accept) state_d = StFin;
        StFin: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    w_data = 8'h00;
    case (state_q)
      StSync0: w_data = 8'hAA;
      StSync1: w_data = 8'h55;
      StWid:   w_data = WidByte;
      StHgt:   w_data = HgtByte;
      StPix:   w_data = pix_q;
      StChk:   w_data = chk_q;
      default: w_data = 8'h00;
    endcase
    wr_uart  = accept;
    busy     = (state_q != StIdle) && (state_q != StFin);
    done     = (state_q == StFin);
    mem_addr = addr_q;
  end

endmodule

// File: tb/tb_image_frame_tx.sv
// Randomized self-checking bench for image_frame_tx with a frame-level reference model.
module tb_image_frame_tx;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 2;
  localparam int unsigned AW = 4;
  localparam int unsigned N  = W * H;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data = 8'h00;
  logic          tx_full = 1'b0;
  logic          wr_uart;
  logic [7:0]    w_data;
  logic          busy;
  logic          done;

  int total = 0;
  int bad = 0;

  logic [7:0] ram [0:15];
  logic [7:0] got [$];
  logic [7:0] exp_q [$];
  int dones = 0;
  int viol = 0;
  int max_addr = 0;
  int bp_mode = 0;
  int hold = 0;

  image_frame_tx #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .start    (start),
    .abort    (abort),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .tx_full  (tx_full),
    .wr_uart  (wr_uart),
    .w_data   (w_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: data valid one cycle after the address.
  always @(posedge clk) mem_data <= ram[mem_addr];

  // FIFO-side monitor.
  always @(negedge clk) begin
    if (wr_uart) got.push_back(w_data);
    if (wr_uart && tx_full) viol++;
    if (done) dones++;
    if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
  end

  // Backpressure: 0 none, 1 five-cycle hold before the width byte then random.
  always @(posedge clk) begin
    #1;
    if (bp_mode == 0) begin
      tx_full = 1'b0;
    end else if (got.size() == 2 && hold < 5) begin
      tx_full = 1'b1;
      hold++;
    end else begin
      tx_full = 1'($urandom_range(0, 1));
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Reference frame computed directly from the frame definition.
  task automatic build_expected();
    int sum;
    exp_q.delete();
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'(W));
    exp_q.push_back(8'(H));
    sum = W + H;
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(ram[i]);
      sum += ram[i];
    end
    exp_q.push_back(8'(sum % 256));
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Sends one frame; optionally re-pulses start once got reaches repulse_at bytes.
  task automatic run_frame(input string tag, input int mode, input int repulse_at);
    bit pulsed;
    int c;
    got.delete();
    dones = 0;
    viol = 0;
    max_addr = 0;
    hold = 0;
    bp_mode = mode;
    pulsed = 1'b0;
    build_expected();
    pulse_start();
    for (c = 0; c < 3000 && dones == 0; c++) begin
      @(posedge clk); #2;
      if (!pulsed && repulse_at >= 0 && got.size() == repulse_at) begin
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        pulsed = 1'b1;
      end
    end
    check({tag, "_timeout"}, int'(c < 3000), 1);
    bp_mode = 0;
    repeat (4) @(posedge clk);
    #2;
    check({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
    check({tag, "_dones"}, dones, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_bp_viol"}, viol, 0);
    check({tag, "_maxaddr"}, int'(max_addr <= N - 1), 1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 8'(i);
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr", wr_uart, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", w_data, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Ramp image, no backpressure; checksum 0x22.
    run_frame("t1", 0, -1);
    check("t1_chk", got.size() == 13 ? int'(got[12]) : -1, 8'h22);

    // Same image with width-hold and random backpressure.
    run_frame("t2", 1, -1);

    // All 0xFF: checksum wraps to 0xFE.
    for (int i = 0; i < N; i++) ram[i] = 8'hFF;
    run_frame("t3", 0, -1);
    check("t3_chk", got.size() == 13 ? int'(got[12]) : -1, 8'hFE);

    // Start re-pulsed while the third pixel is in flight.
    for (int i = 0; i < N; i++) ram[i] = 8'(i);
    run_frame("t4", 0, 6);

    // Asynchronous reset mid-pixel, then a fresh frame.
    got.delete();
    bp_mode = 0;
    pulse_start();
    for (int c = 0; c < 200 && got.size() < 6; c++) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t5_wr", wr_uart, 0);
    check("t5_busy", busy, 0);
    check("t5_addr", mem_addr, 0);
    begin
      int n0;
      n0 = got.size();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #2 check("t5_nowrite", got.size(), n0);
    end
    run_frame("t5", 0, -1);

    // Abort during RD_WAIT of pixel 5.
    got.delete();
    dones = 0;
    pulse_start();
    for (int c = 0; c < 200 && got.size() < 9; c++) begin
      @(posedge clk); #1;
    end
    // Now in RD_REQ for pixel 5; next cycle is RD_WAIT.
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    check("t6_len", got.size(), 9);
    check("t6_dones", dones, 0);
    check("t6_busy", busy, 0);
    run_frame("t6", 0, -1);

    // Abort coincident with start in idle: frame must not start.
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    #1 check("t7_busy", busy, 0);

    // Random images under random backpressure.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) ram[i] = 8'($urandom_range(0, 255));
      run_frame($sformatf("r%0d", k), 1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
